interrupt_ack_sequencer: RTL
============================

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 irq_pending  input  1  priority resolver has an unmasked request.
REQ-004 highest_priority  input  8  one-hot winning IR line from priority resolver (bit n = IRn).
REQ-005 inta_n  input  1  CPU interrupt-acknowledge strobe, active-low, synchronous to clk.
REQ-006 eoi_cmd  input  1  one-cycle strobe from command decoder for a non-specific EOI (OCW2) write.
REQ-007 vector_base  input  5  ICW2 bits T7..T3.
REQ-008 aeoi_mode  input  1  ICW4 automatic-EOI bit; used only per REQ-030.
REQ-009 int_out  output  1  interrupt request to CPU, active-high.
REQ-010 inta_count  output  2  acknowledge phase to in-service register: 0 idle, 1 after first INTA, 2 after second INTA.
REQ-011 eoi  output  1  one-cycle end-of-interrupt pulse to in-service register.
REQ-012 vector_out  output  8  interrupt vector {vector_base, irq_id}.
REQ-013 vector_oe  output  1  data-bus drive enable for vector_out.
REQ-014 irq_id  output  3  binary index of the IR line being acknowledged.

Function
REQ-015 States: IDLE, REQ, ACK1, ACK2, SERVICE; one-hot or binary encoding is free.
REQ-016 INTA falling edge = inta_n_q==1 and inta_n==0, where inta_n_q is inta_n registered one cycle; rising edge symmetric.
REQ-017 IDLE: irq_pending==1 -> REQ; int_out rises the cycle after irq_pending is first sampled high (1-cycle latency).
REQ-018 REQ: int_out=1; irq_pending drops before any INTA falling edge -> IDLE, int_out=0 next cycle, no count change.
REQ-019 REQ + INTA falling edge -> ACK1: int_out=0, inta_count=1, irq_id latched as binary encode of highest_priority, all registered on that edge.
REQ-020 highest_priority==0 at the first INTA falling edge (spurious) -> irq_id=7.
REQ-021 highest_priority with more than one bit set -> irq_id = index of lowest set bit.
REQ-022 ACK1 + INTA falling edge -> ACK2: inta_count=2, vector_oe=1, vector_out={vector_base, irq_id}.
REQ-023 vector_out SHALL be 0 whenever vector_oe==0.
REQ-024 ACK2 + INTA rising edge -> vector_oe=0, inta_count=0, next state SERVICE (or IDLE per REQ-030).
REQ-025 SERVICE: int_out held 0 regardless of irq_pending; eoi_cmd -> eoi=1 for exactly one cycle, next state IDLE.
REQ-026 eoi_cmd in any state other than SERVICE -> eoi=1 for one cycle, state unchanged (in-service register clears unconditionally).
REQ-027 INTA falling edge in IDLE or SERVICE is ignored: inta_count, vector_oe, state unchanged.
REQ-028 inta_n rising edge in ACK1 has no effect; only the second falling edge advances.
REQ-029 irq_id holds its latched value until the next first-INTA edge.

Configuration
REQ-030 Macro PIC_AEOI_EN defined: aeoi_mode==1 -> ACK2 INTA rising edge issues eoi=1 for one cycle and goes directly to IDLE (SERVICE skipped); aeoi_mode==0 behaves as without the macro.
REQ-031 Macro PIC_AEOI_EN undefined: aeoi_mode is ignored, ACK2 always exits to SERVICE, eoi comes only from eoi_cmd.

Reset
REQ-032 reset==1 at a rising clk -> state IDLE, int_out=0, inta_count=0, eoi=0, vector_out=0, vector_oe=0, irq_id=0, inta_n_q=1.
REQ-033 Reset mid-sequence (REQ/ACK1/ACK2/SERVICE) aborts immediately; no eoi pulse is generated by reset.
REQ-034 An INTA low level present when reset deasserts SHALL NOT be counted as a falling edge.

Verification
REQ-035 irq_pending=1, highest_priority=8'h08, vector_base=5'h10, two INTA pulses -> int_out rises after 1 cycle, inta_count 0->1->2->0, vector_out=8'h83 with vector_oe=1 during second INTA.
REQ-036 After REQ-035 in SERVICE, eoi_cmd 1-cycle strobe -> eoi=1 exactly one cycle, state IDLE, new irq_pending reasserts int_out.
REQ-037 highest_priority=8'h00 at first INTA, vector_base=5'h08 -> vector_out=8'h47 during second INTA.
REQ-038 irq_pending drops in REQ before INTA -> int_out=0 next cycle, inta_count stays 0; later INTA pulses ignored.
REQ-039 reset asserted while in ACK2 -> next cycle all outputs 0, state IDLE; subsequent INTA rising edge produces no eoi.
REQ-040 PIC_AEOI_EN defined, aeoi_mode=1, full INTA sequence -> eoi=1 for one cycle on second INTA rising edge, no eoi_cmd needed, state IDLE.

Source files
------------

// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Runs the 8259-style INTA handshake. It raises int_out for a pending request
// and counts the two INTA pulses from the CPU. On the first falling edge it
// latches the winning IR index. On the second falling edge it drives the vector
// {vector_base, irq_id} onto the data bus. The block then waits in SERVICE for
// a non-specific EOI. All outputs are registered.
//
// Optional feature: define PIC_AEOI_EN to enable automatic EOI. When it is
// enabled and aeoi_mode is 1, the INTA rising edge that ends the second pulse
// issues eoi and returns straight to IDLE. SERVICE is skipped in that case.
//
// Ports
//   clk              in   system clock, rising-edge active
//   reset            in   synchronous active-high reset
//   irq_pending      in   priority resolver has an unmasked request
//   highest_priority in   [7:0] one-hot winning IR line
//   inta_n           in   CPU interrupt acknowledge, active-low, clk-synchronous
//   eoi_cmd          in   one-cycle non-specific EOI command strobe
//   vector_base      in   [4:0] ICW2 T7..T3
//   aeoi_mode        in   ICW4 automatic-EOI bit (used only with PIC_AEOI_EN)
//   int_out          out  interrupt request to CPU
//   inta_count       out  [1:0] acknowledge phase: 0 idle, 1 first, 2 second
//   eoi              out  one-cycle end-of-interrupt pulse
//   vector_out       out  [7:0] vector; zero whenever vector_oe is low
//   vector_oe        out  data-bus drive enable for vector_out
//   irq_id           out  [2:0] index of the IR line being acknowledged
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_pending,
    input  logic [7:0] highest_priority,
    input  logic       inta_n,
    input  logic       eoi_cmd,
    input  logic [4:0] vector_base,
    input  logic       aeoi_mode,
    output logic       int_out,
    output logic [1:0] inta_count,
    output logic       eoi,
    output logic [7:0] vector_out,
    output logic       vector_oe,
    output logic [2:0] irq_id
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck1,
        StAck2,
        StService
    } state_t;

    state_t     state;
    logic       inta_n_q;
    logic       inta_fall;
    logic       inta_rise;
    logic [2:0] enc_id;
    logic       auto_eoi;

    assign inta_fall = inta_n_q & ~inta_n;
    assign inta_rise = ~inta_n_q & inta_n;

`ifdef PIC_AEOI_EN
    assign auto_eoi = aeoi_mode;
`else
    // aeoi_mode has no effect in this build.
    assign auto_eoi = 1'b0;
    logic unused_aeoi;
    assign unused_aeoi = aeoi_mode;
`endif

    // The lowest set bit wins if several bits are set. An empty vector is a
    // spurious request and resolves to IR7.
    always_comb begin
        enc_id = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (highest_priority[i]) begin
                enc_id = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            // Held high in reset. If INTA is low when reset releases, the edge
            // detector sees a fall in IDLE, and IDLE ignores it.
            inta_n_q   <= 1'b1;
            int_out    <= 1'b0;
            inta_count <= 2'd0;
            eoi        <= 1'b0;
            vector_out <= 8'h00;
            vector_oe  <= 1'b0;
            irq_id     <= 3'd0;
        end else begin
            inta_n_q <= inta_n;
            // The in-service register clears on any EOI command, in any state.
            eoi      <= eoi_cmd;

            unique case (state)
                StIdle: begin
                    if (irq_pending) begin
                        state   <= StReq;
                        int_out <= 1'b1;
                    end
                end

                StReq: begin
                    if (inta_fall) begin
                        state      <= StAck1;
                        int_out    <= 1'b0;
                        inta_count <= 2'd1;
                        irq_id     <= enc_id;
                    end else if (!irq_pending) begin
                        state   <= StIdle;
                        int_out <= 1'b0;
                    end
                end

                StAck1: begin
                    // The rising edge between the two pulses is ignored.
                    if (inta_fall) begin
                        state      <= StAck2;
                        inta_count <= 2'd2;
                        vector_oe  <= 1'b1;
                        vector_out <= {vector_base, irq_id};
                    end
                end

                StAck2: begin
                    if (inta_rise) begin
                        inta_count <= 2'd0;
                        vector_oe  <= 1'b0;
                        vector_out <= 8'h00;
                        if (auto_eoi) begin
                            state <= StIdle;
                            eoi   <= 1'b1;
                        end else begin
                            state <= StService;
                        end
                    end
                end

                StService: begin
                    // int_out stays low until the handler signals EOI.
                    if (eoi_cmd) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
